// File: rtl/spi_cfg_arbiter.sv
// -----------------------------------------------------------------------------
// spi_cfg_arbiter
//
// Shares one spi_master between NUM_CH configuration engines (ad9517_cfg,
// adc_cfg, ...). A round-robin arbiter grants the bus to one engine for the
// whole of its configuration sequence (as long as it holds i_req). While the
// grant is held:
//   - the granted engine's write/read strobes and write word are registered
//     onto the master command port; strobes from other engines are dropped,
//   - the master's ncs pin is steered combinationally onto the granted
//     engine's chip select; all other chip selects stay high,
//   - the granted engine sees the master's busy (extended by a local
//     "command pending" flag so it never sees a gap between its strobe and
//     the master raising busy); every other engine sees busy = 1.
// A grant whose engine stays silent (no strobes, master idle) for
// IDLE_TIMEOUT cycles is force-released, and that engine is locked out until
// it drops i_req once.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   i_req               per-engine bus request
//   o_gnt               one-hot registered grant
//   i_spi_wr_cmd/rd_cmd per-engine command strobes
//   i_spi_wr_data       per-engine write words, channel k at [k*MOSI_DATA_WIDTH +: MOSI_DATA_WIDTH]
//   o_spi_rd_data       master read data broadcast to all engines
//   o_spi_busy          per-engine busy
//   m_spi_*             command / status interface to the shared spi_master
//   m_spi_ncs           master chip-select pin, steered to o_cs_n
//   o_cs_n              device chip selects, active low
//   o_active_ch         index of the granted channel (valid while |o_gnt)
//   o_timeout           one-cycle pulse on a forced release
//   o_timeout_ch        channel of the last forced release (sticky)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module spi_cfg_arbiter #(
  parameter int NUM_CH          = 3,
  parameter int MOSI_DATA_WIDTH = 24,
  parameter int MISO_DATA_WIDTH = 8,
  parameter int IDLE_TIMEOUT    = 1024,
  parameter int CHW             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CH-1:0]                 i_req,
  output logic [NUM_CH-1:0]                 o_gnt,
  input  logic [NUM_CH-1:0]                 i_spi_wr_cmd,
  input  logic [NUM_CH-1:0]                 i_spi_rd_cmd,
  input  logic [NUM_CH*MOSI_DATA_WIDTH-1:0] i_spi_wr_data,
  output logic [MISO_DATA_WIDTH:0]          o_spi_rd_data,
  output logic [NUM_CH-1:0]                 o_spi_busy,
  output logic                              m_spi_wr_cmd,
  output logic                              m_spi_rd_cmd,
  output logic [MOSI_DATA_WIDTH-1:0]        m_spi_wr_data,
  input  logic [MISO_DATA_WIDTH:0]          m_spi_rd_data,
  input  logic                              m_spi_busy,
  input  logic                              m_spi_ncs,
  output logic [NUM_CH-1:0]                 o_cs_n,
  output logic [CHW-1:0]                    o_active_ch,
  output logic                              o_timeout,
  output logic [CHW-1:0]                    o_timeout_ch
);

  localparam int CNTW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                     state_q,      state_d;
  logic [NUM_CH-1:0]          gnt_q,        gnt_d;
  logic [CHW-1:0]             active_ch_q,  active_ch_d;
  logic [CHW-1:0]             rr_ptr_q,     rr_ptr_d;
  logic                       wr_cmd_q,     wr_cmd_d;
  logic                       rd_cmd_q,     rd_cmd_d;
  logic [MOSI_DATA_WIDTH-1:0] wr_data_q,    wr_data_d;
  logic                       pending_q,    pending_d;
  logic [CNTW-1:0]            idle_cnt_q,   idle_cnt_d;
  logic                       timeout_q,    timeout_d;
  logic [CHW-1:0]             timeout_ch_q, timeout_ch_d;
  // Engines that were force-released and have not yet dropped i_req.
  logic [NUM_CH-1:0]          lock_q,       lock_d;

  logic [NUM_CH-1:0]          eligible;
  logic                       sel_found;
  logic [CHW-1:0]             sel_ch;
  logic [CHW:0]               scan_idx;

  logic                       req_g;
  logic                       fwd_wr;
  logic                       fwd_rd;
  logic                       fwd_any;
  logic                       quiet;
  logic                       timeout_hit;
  logic                       release_now;
  logic [CHW-1:0]             next_ch;
  logic [MOSI_DATA_WIDTH-1:0] wdata_g;

  // ---------------------------------------------------------------------------
  // Round-robin selection: first eligible request scanning from rr_ptr,
  // wrapping at NUM_CH-1 (NUM_CH need not be a power of two).
  // ---------------------------------------------------------------------------
  assign eligible = i_req & ~lock_q;

  always_comb begin : rr_select
    sel_found = 1'b0;
    sel_ch    = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = {1'b0, rr_ptr_q} + (CHW+1)'(i);
      if (scan_idx >= (CHW+1)'(NUM_CH)) begin
        scan_idx = scan_idx - (CHW+1)'(NUM_CH);
      end
      if (!sel_found && eligible[scan_idx[CHW-1:0]]) begin
        sel_found = 1'b1;
        sel_ch    = scan_idx[CHW-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Granted-channel views
  // ---------------------------------------------------------------------------
  assign req_g       = i_req[active_ch_q];
  assign wdata_g     = i_spi_wr_data[int'(active_ch_q)*MOSI_DATA_WIDTH +: MOSI_DATA_WIDTH];
  // Strobes are only accepted in GRANT; once an engine has dropped i_req
  // (DRAIN) it no longer owns the command port.
  assign fwd_wr      = (state_q == ST_GRANT) && i_spi_wr_cmd[active_ch_q];
  assign fwd_rd      = (state_q == ST_GRANT) && i_spi_rd_cmd[active_ch_q];
  assign fwd_any     = fwd_wr || fwd_rd;
  assign quiet       = !fwd_any && !m_spi_busy;
  assign timeout_hit = quiet && (idle_cnt_q == CNTW'(IDLE_TIMEOUT - 1));
  assign next_ch     = (active_ch_q == CHW'(NUM_CH - 1)) ? '0 : active_ch_q + CHW'(1);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gnt_q        <= '0;
      active_ch_q  <= '0;
      rr_ptr_q     <= '0;
      wr_cmd_q     <= 1'b0;
      rd_cmd_q     <= 1'b0;
      wr_data_q    <= '0;
      pending_q    <= 1'b0;
      idle_cnt_q   <= '0;
      timeout_q    <= 1'b0;
      timeout_ch_q <= '0;
      lock_q       <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      active_ch_q  <= active_ch_d;
      rr_ptr_q     <= rr_ptr_d;
      wr_cmd_q     <= wr_cmd_d;
      rd_cmd_q     <= rd_cmd_d;
      wr_data_q    <= wr_data_d;
      pending_q    <= pending_d;
      idle_cnt_q   <= idle_cnt_d;
      timeout_q    <= timeout_d;
      timeout_ch_q <= timeout_ch_d;
      lock_q       <= lock_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin : next_state
    state_d      = state_q;
    gnt_d        = gnt_q;
    active_ch_d  = active_ch_q;
    rr_ptr_d     = rr_ptr_q;
    wr_cmd_d     = fwd_wr;
    rd_cmd_d     = fwd_rd;
    // The master word only changes on a forwarded write, so it stays stable
    // for the whole transfer the master is shifting out.
    wr_data_d    = fwd_wr ? wdata_g : wr_data_q;
    pending_d    = pending_q;
    idle_cnt_d   = '0;
    timeout_d    = 1'b0;
    timeout_ch_d = timeout_ch_q;
    lock_d       = lock_q & i_req;
    release_now  = 1'b0;

    // Bridges the cycle(s) between a forwarded strobe and the master raising
    // busy, so the engine never sees a false "idle".
    if (fwd_any) begin
      pending_d = 1'b1;
    end else if (m_spi_busy) begin
      pending_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          state_d     = ST_GRANT;
          gnt_d       = NUM_CH'(1) << sel_ch;
          active_ch_d = sel_ch;
        end
      end
      ST_GRANT: begin
        if (!req_g) begin
          // A strobe arriving with the falling request is still forwarded,
          // so it must be drained as well.
          if (m_spi_busy || pending_q || fwd_any) begin
            state_d = ST_DRAIN;
          end else begin
            release_now = 1'b1;
          end
        end else if (timeout_hit) begin
          release_now          = 1'b1;
          timeout_d            = 1'b1;
          timeout_ch_d         = active_ch_q;
          lock_d[active_ch_q]  = 1'b1;
        end else if (quiet) begin
          idle_cnt_d = idle_cnt_q + CNTW'(1);
        end
      end
      ST_DRAIN: begin
        if (!m_spi_busy && !pending_q) begin
          release_now = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    // Release always passes through IDLE, so consecutive grants are separated
    // by at least one idle cycle.
    if (release_now) begin
      state_d   = ST_IDLE;
      gnt_d     = '0;
      rr_ptr_d  = next_ch;
      pending_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: chip-select steering and per-engine busy
  // ---------------------------------------------------------------------------
  always_comb begin : outputs
    o_cs_n     = '1;
    o_spi_busy = '1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (gnt_q[k]) begin
        // Pass-through keeps ncs aligned with sclk; ungranted devices stay
        // deselected, and a reset clears gnt_q so no cs_n can glitch low.
        o_cs_n[k]     = m_spi_ncs;
        o_spi_busy[k] = m_spi_busy | pending_q;
      end
    end
  end

  assign o_gnt         = gnt_q;
  assign o_active_ch   = active_ch_q;
  assign o_timeout     = timeout_q;
  assign o_timeout_ch  = timeout_ch_q;
  assign m_spi_wr_cmd  = wr_cmd_q;
  assign m_spi_rd_cmd  = rd_cmd_q;
  assign m_spi_wr_data = wr_data_q;
  assign o_spi_rd_data = m_spi_rd_data;

endmodule

// File: tb/tb_spi_cfg_arbiter.sv
`timescale 1ns/1ps

module tb_spi_cfg_arbiter;

  localparam int N  = 3;
  localparam int W  = 24;
  localparam int R  = 8;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   i_req, i_wr, i_rd;
  logic [N*W-1:0] i_wdata;
  logic [R:0]     m_rd_data;
  logic           m_busy, m_ncs;

  logic [N-1:0]   o_gnt, o_spi_busy, o_cs_n;
  logic [R:0]     o_spi_rd_data;
  logic           m_wr_cmd, m_rd_cmd, o_timeout;
  logic [W-1:0]   m_wr_data;
  logic [1:0]     o_active_ch, o_timeout_ch;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_cfg_arbiter #(
    .NUM_CH(N), .MOSI_DATA_WIDTH(W), .MISO_DATA_WIDTH(R), .IDLE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .o_gnt(o_gnt),
    .i_spi_wr_cmd(i_wr), .i_spi_rd_cmd(i_rd), .i_spi_wr_data(i_wdata),
    .o_spi_rd_data(o_spi_rd_data), .o_spi_busy(o_spi_busy),
    .m_spi_wr_cmd(m_wr_cmd), .m_spi_rd_cmd(m_rd_cmd), .m_spi_wr_data(m_wr_data),
    .m_spi_rd_data(m_rd_data), .m_spi_busy(m_busy), .m_spi_ncs(m_ncs),
    .o_cs_n(o_cs_n), .o_active_ch(o_active_ch),
    .o_timeout(o_timeout), .o_timeout_ch(o_timeout_ch)
  );

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req = '0; i_wr = '0; i_rd = '0; i_wdata = '0;
    m_busy = 1'b0; m_ncs = 1'b1; m_rd_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: who owns the bus, whether it is draining, and the
  // bookkeeping the arbitration rules need, advanced once per clock edge.
  // ---------------------------------------------------------------------------
  int         owner;      // -1 = bus free
  int         rr;
  int         quiet_cnt;
  bit         draining, pending;
  bit         locked [N];
  bit         e_wr, e_rd, e_to;
  logic [W-1:0] e_data;
  int         e_to_ch;

  task automatic model_reset();
    owner = -1; rr = 0; quiet_cnt = 0; draining = 0; pending = 0;
    for (int k = 0; k < N; k++) locked[k] = 0;
    e_wr = 0; e_rd = 0; e_to = 0; e_data = '0; e_to_ch = 0;
  endtask

  task automatic release_bus();
    rr        = (owner + 1) % N;
    owner     = -1;
    draining  = 0;
    quiet_cnt = 0;
    pending   = 0;
  endtask

  task automatic model_step();
    bit fired, was_pending;
    e_wr = 0; e_rd = 0; e_to = 0;
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < N; k++) if (!i_req[k]) locked[k] = 0;
    if (owner < 0) begin
      for (int i = 0; i < N; i++) begin
        int c = (rr + i) % N;
        if (i_req[c] && !locked[c]) begin
          owner = c;
          break;
        end
      end
    end else if (!draining) begin
      fired = i_wr[owner] || i_rd[owner];
      e_wr  = i_wr[owner];
      e_rd  = i_rd[owner];
      if (i_wr[owner]) e_data = i_wdata[owner*W +: W];
      was_pending = pending;
      if (fired) pending = 1;
      else if (m_busy) pending = 0;
      if (!i_req[owner]) begin
        if (m_busy || was_pending || fired) draining = 1;
        else release_bus();
      end else if (!fired && !m_busy && quiet_cnt == TO - 1) begin
        e_to = 1; e_to_ch = owner; locked[owner] = 1;
        release_bus();
      end else begin
        quiet_cnt = (fired || m_busy) ? 0 : quiet_cnt + 1;
      end
    end else begin
      was_pending = pending;
      if (m_busy) pending = 0;
      if (!m_busy && !was_pending) release_bus();
    end
  endtask

  function automatic logic [N-1:0] onehot(int o);
    return (o < 0) ? '0 : N'(1 << o);
  endfunction

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [N-1:0]   req, wr;
    logic [N*W-1:0] wdata;
    logic           busy, ncs;
    logic [N-1:0]   x_cs_n, x_busy, x_gnt;
    logic           x_wr;
    logic [W-1:0]   x_data;
  } vec_t;

  function automatic vec_t mk(logic [2:0] req, logic [2:0] wr, logic [71:0] wd,
                              logic busy, logic ncs, logic [2:0] xcs, logic [2:0] xbusy,
                              logic [2:0] xgnt, logic xwr, logic [23:0] xd);
    vec_t v;
    v.req = req; v.wr = wr; v.wdata = wd; v.busy = busy; v.ncs = ncs;
    v.x_cs_n = xcs; v.x_busy = xbusy; v.x_gnt = xgnt; v.x_wr = xwr; v.x_data = xd;
    return v;
  endfunction

  vec_t tv[18];
  logic [N-1:0] order[4];
  logic [N-1:0] ecs, ebusy;
  int sp;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = mk(3'b001, 3'b000, 72'h0,                          0, 1, 3'b111, 3'b111, 3'b001, 0, 24'h0);
    tv[1]  = mk(3'b001, 3'b001, {24'h0, 24'h0, 24'h000A5A},     0, 1, 3'b111, 3'b110, 3'b001, 1, 24'h000A5A);
    tv[2]  = mk(3'b001, 3'b000, 72'h0,                          0, 0, 3'b110, 3'b111, 3'b001, 0, 24'h0);
    tv[3]  = mk(3'b001, 3'b000, 72'h0,                          1, 0, 3'b110, 3'b111, 3'b001, 0, 24'h0);
    tv[4]  = mk(3'b001, 3'b000, 72'h0,                          0, 1, 3'b111, 3'b110, 3'b001, 0, 24'h0);
    tv[5]  = mk(3'b000, 3'b000, 72'h0,                          0, 1, 3'b111, 3'b110, 3'b000, 0, 24'h0);
    tv[6]  = mk(3'b110, 3'b000, 72'h0,                          0, 1, 3'b111, 3'b111, 3'b010, 0, 24'h0);
    tv[7]  = mk(3'b110, 3'b101, {24'hFFFFFF, 24'h123456, 24'hFFFFFF}, 0, 0, 3'b101, 3'b101, 3'b010, 0, 24'h0);
    tv[8]  = mk(3'b110, 3'b010, {24'h0, 24'h123456, 24'h0},     0, 1, 3'b111, 3'b101, 3'b010, 1, 24'h123456);
    tv[9]  = mk(3'b100, 3'b000, 72'h0,                          1, 1, 3'b111, 3'b111, 3'b010, 0, 24'h0);
    tv[10] = mk(3'b100, 3'b000, 72'h0,                          1, 1, 3'b111, 3'b111, 3'b010, 0, 24'h0);
    tv[11] = mk(3'b100, 3'b000, 72'h0,                          0, 1, 3'b111, 3'b101, 3'b000, 0, 24'h0);
    tv[12] = mk(3'b100, 3'b000, 72'h0,                          0, 1, 3'b111, 3'b111, 3'b100, 0, 24'h0);
    tv[13] = mk(3'b100, 3'b100, {24'hABCDEF, 24'h0, 24'h0},     0, 0, 3'b011, 3'b011, 3'b100, 1, 24'hABCDEF);
    tv[14] = mk(3'b000, 3'b000, 72'h0,                          0, 1, 3'b111, 3'b111, 3'b100, 0, 24'h0);
    tv[15] = mk(3'b000, 3'b000, 72'h0,                          1, 0, 3'b011, 3'b111, 3'b100, 0, 24'h0);
    tv[16] = mk(3'b000, 3'b000, 72'h0,                          0, 1, 3'b111, 3'b011, 3'b000, 0, 24'h0);
    tv[17] = mk(3'b000, 3'b000, 72'h0,                          0, 1, 3'b111, 3'b111, 3'b000, 0, 24'h0);
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;

    // Reset values
    do_reset();
    chk("rst_gnt",     72'(o_gnt),        72'(3'b000));
    chk("rst_wr_cmd",  72'(m_wr_cmd),     72'(1'b0));
    chk("rst_rd_cmd",  72'(m_rd_cmd),     72'(1'b0));
    chk("rst_wr_data", 72'(m_wr_data),    72'(24'h0));
    chk("rst_cs_n",    72'(o_cs_n),       72'(3'b111));
    chk("rst_busy",    72'(o_spi_busy),   72'(3'b111));
    chk("rst_act_ch",  72'(o_active_ch),  72'(2'd0));
    chk("rst_to",      72'(o_timeout),    72'(1'b0));
    chk("rst_to_ch",   72'(o_timeout_ch), 72'(2'd0));

    // Directed table: grant, forwarding, dropped strobes, drain
    for (int i = 0; i < 18; i++) begin
      i_req = tv[i].req; i_wr = tv[i].wr; i_wdata = tv[i].wdata;
      m_busy = tv[i].busy; m_ncs = tv[i].ncs;
      #1;
      chk($sformatf("tv%0d_cs_n", i), 72'(o_cs_n),     72'(tv[i].x_cs_n));
      chk($sformatf("tv%0d_busy", i), 72'(o_spi_busy), 72'(tv[i].x_busy));
      tick();
      chk($sformatf("tv%0d_gnt", i),    72'(o_gnt),    72'(tv[i].x_gnt));
      chk($sformatf("tv%0d_wr_cmd", i), 72'(m_wr_cmd), 72'(tv[i].x_wr));
      if (tv[i].x_wr) chk($sformatf("tv%0d_wr_data", i), 72'(m_wr_data), 72'(tv[i].x_data));
    end

    // Round-robin order with all engines requesting
    do_reset();
    i_req = 3'b111;
    tick();
    chk("rr_first", 72'(o_gnt), 72'(order[0]));
    for (int g = 0; g < 3; g++) begin
      i_wr = order[g];
      tick();
      chk($sformatf("rr%0d_wr_cmd", g), 72'(m_wr_cmd), 72'(1'b1));
      i_wr = '0; m_busy = 1'b1; i_req = 3'b111 & ~order[g];
      tick();
      m_busy = 1'b0;
      tick();
      chk($sformatf("rr%0d_idle_gap", g), 72'(o_gnt), 72'(3'b000));
      i_req = 3'b111;
      tick();
      chk($sformatf("rr%0d_next", g), 72'(o_gnt), 72'(order[g+1]));
    end

    // Idle timeout on ch1, ch2 served next, ch1 locked out until it re-requests
    do_reset();
    i_req = 3'b110;
    tick();
    chk("to_gnt", 72'(o_gnt), 72'(3'b010));
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (k < TO) begin
        chk($sformatf("to_wait%0d", k), 72'({o_timeout, o_gnt}), 72'({1'b0, 3'b010}));
      end else begin
        chk("to_pulse", 72'(o_timeout),    72'(1'b1));
        chk("to_rel",   72'(o_gnt),        72'(3'b000));
        chk("to_ch",    72'(o_timeout_ch), 72'(2'd1));
      end
    end
    tick();
    chk("to_next_ch2", 72'(o_gnt),        72'(3'b100));
    chk("to_pulse_end", 72'(o_timeout),   72'(1'b0));
    chk("to_ch_sticky", 72'(o_timeout_ch), 72'(2'd1));
    i_req = 3'b010;
    tick();
    chk("to_ch2_rel", 72'(o_gnt), 72'(3'b000));
    tick();
    chk("to_lockout", 72'(o_gnt), 72'(3'b000));
    i_req = 3'b000;
    tick();
    i_req = 3'b010;
    tick();
    chk("to_rereq", 72'(o_gnt), 72'(3'b010));

    // Reset in the middle of a transfer
    do_reset();
    i_req = 3'b001;
    tick();
    chk("mr_gnt", 72'(o_gnt), 72'(3'b001));
    i_wr = 3'b001; i_wdata = {24'h0, 24'h0, 24'h5A5A5A}; m_ncs = 1'b0;
    tick();
    chk("mr_wr_cmd", 72'(m_wr_cmd), 72'(1'b1));
    chk("mr_cs_n",   72'(o_cs_n),   72'(3'b110));
    rst = 1'b1;
    tick();
    chk("mr_gnt0",   72'(o_gnt),      72'(3'b000));
    chk("mr_cs_n1",  72'(o_cs_n),     72'(3'b111));
    chk("mr_busy1",  72'(o_spi_busy), 72'(3'b111));
    chk("mr_wr0",    72'(m_wr_cmd),   72'(1'b0));
    chk("mr_data0",  72'(m_wr_data),  72'(24'h0));
    rst = 1'b0; i_wr = '0;

    // Randomised run against the reference model
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      chk("rnd_gnt",    72'(o_gnt),        72'(onehot(owner)));
      chk("rnd_wr_cmd", 72'(m_wr_cmd),     72'(e_wr));
      chk("rnd_rd_cmd", 72'(m_rd_cmd),     72'(e_rd));
      chk("rnd_to",     72'(o_timeout),    72'(e_to));
      chk("rnd_to_ch",  72'(o_timeout_ch), 72'(e_to_ch));
      if (e_wr) chk("rnd_wr_data", 72'(m_wr_data), 72'(e_data));
      if (owner >= 0) chk("rnd_act_ch", 72'(o_active_ch), 72'(owner));

      sp = ((cyc / 500) % 2 == 0) ? 11 : 59;
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 39) == 0) i_req[k] = ~i_req[k];
        i_wr[k] = ($urandom_range(0, sp) == 0);
        i_rd[k] = ($urandom_range(0, 3*sp) == 0);
        i_wdata[k*W +: W] = W'($urandom);
      end
      if (m_busy) m_busy = ($urandom_range(0, 2) != 0);
      else        m_busy = ($urandom_range(0, 9) == 0);
      m_ncs     = 1'($urandom);
      m_rd_data = (R+1)'($urandom);
      rst       = ($urandom_range(0, 599) == 0);
      #1;
      ecs = '1; ebusy = '1;
      if (owner >= 0) begin
        ecs[owner]   = m_ncs;
        ebusy[owner] = m_busy | pending;
      end
      chk("rnd_cs_n",    72'(o_cs_n),        72'(ecs));
      chk("rnd_busy",    72'(o_spi_busy),    72'(ebusy));
      chk("rnd_rd_data", 72'(o_spi_rd_data), 72'(m_rd_data));
      model_step();
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
